// File: rtl/kf8255_bus_master_if.sv
// Bus bundle between a requester, the kf8255 bus master and the 8255-style peripheral.
// The master modport is the bus master's view; slave is the surrounding environment.
interface kf8255_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_address;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic [1:0] address;
  logic [7:0] data_bus_out;
  logic       data_bus_oe;
  logic [7:0] data_bus_in;

  modport master (
    input  req_valid, req_write, req_address, req_wdata, data_bus_in,
    output req_ready, rsp_valid, rsp_rdata, chip_select_n, read_enable_n,
           write_enable_n, address, data_bus_out, data_bus_oe
  );

  modport slave (
    output req_valid, req_write, req_address, req_wdata, data_bus_in,
    input  req_ready, rsp_valid, rsp_rdata, chip_select_n, read_enable_n,
           write_enable_n, address, data_bus_out, data_bus_oe
  );
endinterface

// File: rtl/kf8255_bus_master.sv
// Sequences one 8255 register access at a time: SETUP, STROBE and HOLD phases
// of programmable length, with all bus outputs driven straight from flops.
module kf8255_bus_master #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  kf8255_bus_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

  state_t     state_q;
  logic [3:0] count_q;
  logic       write_q;
  logic       ready_q;
  logic       rsp_valid_q;
  logic [7:0] rdata_q;
  logic       cs_n_q;
  logic       re_n_q;
  logic       we_n_q;
  logic [1:0] addr_q;
  logic [7:0] dout_q;
  logic       oe_q;

  // The counter holds the remaining cycles in the current phase minus one,
  // so each phase ends on the edge where it reads zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= 4'd0;
      write_q     <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'd0;
      cs_n_q      <= 1'b1;
      re_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      addr_q      <= 2'd0;
      dout_q      <= 8'd0;
      oe_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ready_q && bus.req_valid) begin
            state_q <= SETUP;
            count_q <= SETUP_LOAD;
            ready_q <= 1'b0;
            write_q <= bus.req_write;
            addr_q  <= bus.req_address;
            dout_q  <= bus.req_wdata;
            oe_q    <= bus.req_write;
            cs_n_q  <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SETUP: begin
          if (count_q == 4'd0) begin
            state_q <= STROBE;
            count_q <= STROBE_LOAD;
            re_n_q  <= write_q;
            we_n_q  <= ~write_q;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        STROBE: begin
          if (count_q == 4'd0) begin
            state_q <= HOLD;
            count_q <= HOLD_LOAD;
            re_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            if (!write_q) begin
              rdata_q <= bus.data_bus_in;
            end
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        HOLD: begin
          // Returning to IDLE raises ready together with the completion pulse,
          // which is what lets a held request start back-to-back.
          if (count_q == 4'd0) begin
            state_q     <= IDLE;
            cs_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.chip_select_n  = cs_n_q;
  assign bus.read_enable_n  = re_n_q;
  assign bus.write_enable_n = we_n_q;
  assign bus.address        = addr_q;
  assign bus.data_bus_out   = dout_q;
  assign bus.data_bus_oe    = oe_q;

endmodule

// File: tb/tb_kf8255_bus_master.sv
// Bench for kf8255_bus_master: one default-timing instance and one 2/3/2 instance,
// checked every cycle against a cycle-offset model plus literal expectations.
module tb_kf8255_bus_master;

  logic clock;
  logic reset_n;

  logic       reqValid   [2];
  logic       reqWrite   [2];
  logic [1:0] reqAddress [2];
  logic [7:0] reqWdata   [2];
  logic [7:0] dataIn     [2];

  logic       readyO [2];
  logic       rspO   [2];
  logic [7:0] rdataO [2];
  logic       csO    [2];
  logic       reO    [2];
  logic       weO    [2];
  logic [1:0] addrO  [2];
  logic [7:0] doutO  [2];
  logic       oeO    [2];

  int testCount = 0;
  int failCount = 0;

  int setupC  [2] = '{1, 2};
  int strobeC [2] = '{2, 3};
  int holdC   [2] = '{1, 2};

  kf8255_bus_master_if if0 ();
  kf8255_bus_master_if if1 ();

  kf8255_bus_master u0 (.clock(clock), .reset_n(reset_n), .bus(if0));

  kf8255_bus_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u1 (
    .clock(clock), .reset_n(reset_n), .bus(if1)
  );

  assign if0.req_valid   = reqValid[0];
  assign if0.req_write   = reqWrite[0];
  assign if0.req_address = reqAddress[0];
  assign if0.req_wdata   = reqWdata[0];
  assign if0.data_bus_in = dataIn[0];
  assign if1.req_valid   = reqValid[1];
  assign if1.req_write   = reqWrite[1];
  assign if1.req_address = reqAddress[1];
  assign if1.req_wdata   = reqWdata[1];
  assign if1.data_bus_in = dataIn[1];

  assign readyO[0] = if0.req_ready;      assign readyO[1] = if1.req_ready;
  assign rspO[0]   = if0.rsp_valid;      assign rspO[1]   = if1.rsp_valid;
  assign rdataO[0] = if0.rsp_rdata;      assign rdataO[1] = if1.rsp_rdata;
  assign csO[0]    = if0.chip_select_n;  assign csO[1]    = if1.chip_select_n;
  assign reO[0]    = if0.read_enable_n;  assign reO[1]    = if1.read_enable_n;
  assign weO[0]    = if0.write_enable_n; assign weO[1]    = if1.write_enable_n;
  assign addrO[0]  = if0.address;        assign addrO[1]  = if1.address;
  assign doutO[0]  = if0.data_bus_out;   assign doutO[1]  = if1.data_bus_out;
  assign oeO[0]    = if0.data_bus_oe;    assign oeO[1]    = if1.data_bus_oe;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int act, input int exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a transaction is described only by how many cycles have passed
  // since it was accepted; the phase windows follow from the three lengths.
  logic       mActive [2];
  logic       mReady  [2];
  logic       mRsp    [2];
  logic [7:0] mRdata  [2];
  logic       mWrite  [2];
  logic [1:0] mAddr   [2];
  logic [7:0] mData   [2];
  int         mK      [2];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mActive[i] <= 1'b0;
        mReady[i]  <= 1'b0;
        mRsp[i]    <= 1'b0;
        mRdata[i]  <= 8'd0;
        mK[i]      <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mRsp[i] <= 1'b0;
        if (!mActive[i]) begin
          if (mReady[i] && reqValid[i]) begin
            mActive[i] <= 1'b1;
            mK[i]      <= 1;
            mWrite[i]  <= reqWrite[i];
            mAddr[i]   <= reqAddress[i];
            mData[i]   <= reqWdata[i];
            mReady[i]  <= 1'b0;
          end else begin
            mReady[i] <= 1'b1;
          end
        end else begin
          if (mK[i] == setupC[i] + strobeC[i] && !mWrite[i]) mRdata[i] <= dataIn[i];
          if (mK[i] == setupC[i] + strobeC[i] + holdC[i]) begin
            mActive[i] <= 1'b0;
            mRsp[i]    <= 1'b1;
            mReady[i]  <= 1'b1;
          end
          mK[i] <= mK[i] + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        automatic bit inStrobe = mActive[i] && mK[i] > setupC[i] &&
                                 mK[i] <= setupC[i] + strobeC[i];
        checkOutput($sformatf("u%0d.req_ready", i), readyO[i], mReady[i]);
        checkOutput($sformatf("u%0d.rsp_valid", i), rspO[i], mRsp[i]);
        checkOutput($sformatf("u%0d.rsp_rdata", i), rdataO[i], mRdata[i]);
        checkOutput($sformatf("u%0d.chip_select_n", i), csO[i], !mActive[i]);
        checkOutput($sformatf("u%0d.write_enable_n", i), weO[i], !(inStrobe && mWrite[i]));
        checkOutput($sformatf("u%0d.read_enable_n", i), reO[i], !(inStrobe && !mWrite[i]));
        checkOutput($sformatf("u%0d.data_bus_oe", i), oeO[i], mActive[i] && mWrite[i]);
        if (mActive[i]) checkOutput($sformatf("u%0d.address", i), addrO[i], mAddr[i]);
        if (mActive[i] && mWrite[i])
          checkOutput($sformatf("u%0d.data_bus_out", i), doutO[i], mData[i]);
      end
    end
  end

  // Length of the most recent chip_select_n high stretch on the default instance.
  int csRun0 = 0;
  int lastHighRun0 = 0;
  always @(negedge clock) begin
    if (csO[0]) csRun0 <= csRun0 + 1;
    else if (csRun0 != 0) begin
      lastHighRun0 <= csRun0;
      csRun0       <= 0;
    end
  end

  // Called just after a negedge; returns at the negedge of the rsp_valid cycle.
  task automatic applyStimulus(input int i, input bit w, input logic [1:0] a,
                               input logic [7:0] d, input logic [7:0] din1,
                               input logic [7:0] din2, input bit keep,
                               output int lat, output int csLow,
                               output int stbLow, output int oeCnt);
    bit found = 0;
    lat = 0; csLow = 0; stbLow = 0; oeCnt = 0;
    reqValid[i] = 1'b1; reqWrite[i] = w; reqAddress[i] = a; reqWdata[i] = d;
    for (int n = 0; n < 40 && !found; n++) begin
      if (readyO[i]) found = 1;
      else @(negedge clock);
    end
    checkOutput($sformatf("u%0d.accept_timeout", i), found, 1);
    if (!found) return;
    @(posedge clock);
    @(negedge clock);
    lat = 1;
    if (!keep) reqValid[i] = 1'b0;
    reqWrite[i] = ~w; reqAddress[i] = ~a; reqWdata[i] = ~d;
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (rspO[i]) found = 1;
      else begin
        if (!csO[i]) csLow++;
        if (oeO[i]) oeCnt++;
        if (!reO[i] || !weO[i]) begin
          dataIn[i] = (stbLow == 0) ? din1 : din2;
          stbLow++;
        end
        @(negedge clock);
        lat++;
      end
    end
    checkOutput($sformatf("u%0d.rsp_timeout", i), found, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s.u%0d.cs_n", tag, i), csO[i], 1);
      checkOutput($sformatf("%s.u%0d.re_n", tag, i), reO[i], 1);
      checkOutput($sformatf("%s.u%0d.we_n", tag, i), weO[i], 1);
      checkOutput($sformatf("%s.u%0d.address", tag, i), addrO[i], 0);
      checkOutput($sformatf("%s.u%0d.dout", tag, i), doutO[i], 0);
      checkOutput($sformatf("%s.u%0d.oe", tag, i), oeO[i], 0);
      checkOutput($sformatf("%s.u%0d.rsp_valid", tag, i), rspO[i], 0);
      checkOutput($sformatf("%s.u%0d.rdata", tag, i), rdataO[i], 0);
      checkOutput($sformatf("%s.u%0d.ready", tag, i), readyO[i], 0);
    end
  endtask

  initial begin
    int lat, csLow, stbLow, oeCnt, reCount, rspCount;
    bit hit;
    for (int i = 0; i < 2; i++) begin
      reqValid[i] = 0; reqWrite[i] = 0; reqAddress[i] = 0; reqWdata[i] = 0; dataIn[i] = 0;
    end
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("ready_after_reset.u0", readyO[0], 1);
    checkOutput("ready_after_reset.u1", readyO[1], 1);

    applyStimulus(0, 1'b1, 2'd3, 8'h80, 8'h00, 8'h00, 1'b0, lat, csLow, stbLow, oeCnt);
    checkOutput("wr_ctrl.latency", lat, 5);
    checkOutput("wr_ctrl.cs_low", csLow, 4);
    checkOutput("wr_ctrl.we_low", stbLow, 2);
    checkOutput("wr_ctrl.oe_cycles", oeCnt, 4);
    checkOutput("wr_ctrl.rdata_kept", rdataO[0], 8'h00);

    @(negedge clock);
    applyStimulus(0, 1'b0, 2'd0, 8'h00, 8'hA5, 8'hA5, 1'b0, lat, csLow, stbLow, oeCnt);
    checkOutput("rd_a.re_low", stbLow, 2);
    checkOutput("rd_a.oe_cycles", oeCnt, 0);
    checkOutput("rd_a.rdata", rdataO[0], 8'hA5);

    @(negedge clock);
    applyStimulus(0, 1'b0, 2'd1, 8'h00, 8'h11, 8'h22, 1'b0, lat, csLow, stbLow, oeCnt);
    checkOutput("rd_last_strobe.rdata", rdataO[0], 8'h22);

    @(negedge clock);
    applyStimulus(0, 1'b1, 2'd2, 8'h3C, 8'h00, 8'h00, 1'b1, lat, csLow, stbLow, oeCnt);
    applyStimulus(0, 1'b0, 2'd1, 8'h00, 8'h5A, 8'h5A, 1'b0, lat, csLow, stbLow, oeCnt);
    checkOutput("b2b.second_latency", lat, 5);
    checkOutput("b2b.cs_high_gap", lastHighRun0, 1);
    checkOutput("b2b.rdata", rdataO[0], 8'h5A);

    @(negedge clock);
    reqValid[0] = 1'b1; reqWrite[0] = 1'b0; reqAddress[0] = 2'd2; dataIn[0] = 8'hC3;
    hit = 0;
    for (int n = 0; n < 20 && !hit; n++) begin
      if (readyO[0]) hit = 1;
      else @(negedge clock);
    end
    @(posedge clock);
    @(negedge clock);
    reqValid[0] = 1'b0;
    reCount = 0;
    for (int n = 0; n < 20 && reCount < 2; n++) begin
      if (!reO[0]) reCount++;
      if (reCount < 2) @(negedge clock);
    end
    checkOutput("midreset.reached_strobe2", reCount, 2);
    #1 reset_n = 1'b0;
    #1 checkResetOutputs("midreset");
    @(negedge clock);
    #2 reset_n = 1'b1;
    rspCount = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (rspO[0]) rspCount++;
    end
    checkOutput("midreset.no_rsp", rspCount, 0);
    checkOutput("midreset.ready", readyO[0], 1);

    applyStimulus(1, 1'b1, 2'd1, 8'h96, 8'h00, 8'h00, 1'b0, lat, csLow, stbLow, oeCnt);
    checkOutput("slow_wr.latency", lat, 8);
    checkOutput("slow_wr.cs_low", csLow, 7);
    checkOutput("slow_wr.we_low", stbLow, 3);

    @(negedge clock);
    applyStimulus(1, 1'b0, 2'd3, 8'h00, 8'h11, 8'h22, 1'b0, lat, csLow, stbLow, oeCnt);
    checkOutput("slow_rd.re_low", stbLow, 3);
    checkOutput("slow_rd.rdata", rdataO[1], 8'h22);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
